// File: rtl/stage_mem_tap_bank.sv
`default_nettype none
// ============================================================================
// Module   : stage_mem_tap_bank
// Brief    : Per-lane tap-coefficient store with registered read, full/sub-word
//            writes and a valid/ready streaming loader.
// Revision : 1.0 - initial release
// ============================================================================
module stage_mem_tap_bank #(
    parameter  int LANES = 6,
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    output logic                   rd_valid,
    output logic [LANES*WIDTH-1:0] rd_data,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [LANES*WIDTH-1:0] wr_data,
    input  logic                   sub_en,
    input  logic [LW-1:0]          sub_lane,
    input  logic [WIDTH-1:0]       sub_data,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [WIDTH-1:0]       ld_data,
    input  logic                   ld_last,
    output logic                   ld_done,
    output logic                   ld_err,
    output logic                   busy
);

    localparam logic [LW-1:0] c_last_lane = LW'(LANES - 1);
    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [LW-1:0] r_lane_cnt, w_lane_cnt_nxt;
    logic [AW-1:0] r_addr_cnt, w_addr_cnt_nxt;
    logic          r_err, w_err_nxt;
    logic          r_rd_valid;
    logic          w_hs;
    logic          w_final;
    logic          w_idle;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_hs    = (r_state == ST_LOAD) && ld_valid;
    assign w_final = (r_lane_cnt == c_last_lane) && (r_addr_cnt == c_last_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_lane_cnt <= '0;
            r_addr_cnt <= '0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lane_cnt <= w_lane_cnt_nxt;
            r_addr_cnt <= w_addr_cnt_nxt;
            r_err      <= w_err_nxt;
            r_rd_valid <= rd_en;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lane_cnt_nxt = r_lane_cnt;
        w_addr_cnt_nxt = r_addr_cnt;
        w_err_nxt      = r_err;
        case (r_state)
            ST_IDLE: begin
                if (ld_start) begin
                    w_state_nxt    = ST_LOAD;
                    w_lane_cnt_nxt = '0;
                    w_addr_cnt_nxt = '0;
                    w_err_nxt      = 1'b0;
                end
            end
            ST_LOAD: begin
                if (w_hs) begin
                    if (w_final) begin
                        w_state_nxt = ST_DONE;
                        w_err_nxt   = r_err | ~ld_last;
                    end else if (ld_last) begin
                        // Early end of frame: stop here, later entries untouched.
                        w_state_nxt = ST_DONE;
                        w_err_nxt   = 1'b1;
                    end else if (r_lane_cnt == c_last_lane) begin
                        w_lane_cnt_nxt = '0;
                        w_addr_cnt_nxt = r_addr_cnt + AW'(1);
                    end else begin
                        w_lane_cnt_nxt = r_lane_cnt + LW'(1);
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy     = (r_state != ST_IDLE);
    assign ld_ready = (r_state == ST_LOAD);
    assign ld_done  = (r_state == ST_DONE);
    assign ld_err   = r_err;
    assign rd_valid = r_rd_valid;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [WIDTH-1:0] r_rd_lane;
        logic             w_sub_hit;
        logic             w_we;
        logic [AW-1:0]    w_waddr;
        logic [WIDTH-1:0] w_wdata;

        assign w_sub_hit = sub_en && (sub_lane == LW'(k));

        // Loader owns the write port while active; host writes only in IDLE.
        always_comb begin
            w_we    = 1'b0;
            w_waddr = wr_addr;
            w_wdata = wr_data[k*WIDTH +: WIDTH];
            if (w_hs) begin
                w_we    = (r_lane_cnt == LW'(k));
                w_waddr = r_addr_cnt;
                w_wdata = ld_data;
            end else if (w_idle) begin
                w_we    = wr_en || w_sub_hit;
                w_wdata = w_sub_hit ? sub_data : wr_data[k*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge clk) begin
            if (w_we) begin
                r_mem[w_waddr] <= w_wdata;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_rd_lane <= '0;
            end else if (rd_en) begin
                r_rd_lane <= (w_we && (w_waddr == rd_addr)) ? w_wdata : r_mem[rd_addr];
            end
        end

        assign rd_data[k*WIDTH +: WIDTH] = r_rd_lane;
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_mem_tap_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_mem_tap_bank
// Brief    : Directed bench with a word-index level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_mem_tap_bank;

    localparam int LANES = 6;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int LW    = 3;
    localparam int NW    = LANES * DEPTH;

    logic                   clk;
    logic                   reset;
    logic                   rd_en;
    logic [AW-1:0]          rd_addr;
    logic                   rd_valid;
    logic [LANES*WIDTH-1:0] rd_data;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [LANES*WIDTH-1:0] wr_data;
    logic                   sub_en;
    logic [LW-1:0]          sub_lane;
    logic [WIDTH-1:0]       sub_data;
    logic                   ld_start;
    logic                   ld_valid;
    logic                   ld_ready;
    logic [WIDTH-1:0]       ld_data;
    logic                   ld_last;
    logic                   ld_done;
    logic                   ld_err;
    logic                   busy;

    stage_mem_tap_bank #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sub_en(sub_en), .sub_lane(sub_lane), .sub_data(sub_data),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .ld_done(ld_done),
        .ld_err(ld_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: loader tracked as a flat word index into the array.
    logic [WIDTH-1:0]       m_mem [DEPTH][LANES];
    bit                     m_loading    = 1'b0;
    bit                     m_done       = 1'b0;
    bit                     m_err        = 1'b0;
    int                     m_idx        = 0;
    bit                     exp_rd_valid = 1'b0;
    logic [LANES*WIDTH-1:0] exp_rd_data  = '0;

    task automatic chk(input string name, input logic [LANES*WIDTH-1:0] act,
                       input logic [LANES*WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading    = 1'b0;
        m_done       = 1'b0;
        m_err        = 1'b0;
        m_idx        = 0;
        exp_rd_valid = 1'b0;
        exp_rd_data  = '0;
    endtask

    task automatic model_step();
        if (!reset) begin
            model_reset();
            return;
        end
        if (!m_loading && !m_done) begin
            if (wr_en)
                for (int l = 0; l < LANES; l++) m_mem[wr_addr][l] = wr_data[l*WIDTH +: WIDTH];
            if (sub_en && int'(sub_lane) < LANES)
                m_mem[wr_addr][sub_lane] = sub_data;
            if (ld_start) begin
                m_loading = 1'b1;
                m_idx     = 0;
                m_err     = 1'b0;
            end
        end else if (m_loading) begin
            if (ld_valid) begin
                m_mem[m_idx / LANES][m_idx % LANES] = ld_data;
                if (m_idx == NW - 1) begin
                    m_err     = m_err | !ld_last;
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                end else if (ld_last) begin
                    m_err     = 1'b1;
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end else begin
            m_done = 1'b0;
        end
        if (rd_en)
            for (int l = 0; l < LANES; l++) exp_rd_data[l*WIDTH +: WIDTH] = m_mem[rd_addr][l];
        exp_rd_valid = rd_en;
    endtask

    always @(negedge clk) begin
        chk("status{busy,ready,done,err,rd_valid}",
            {187'd0, busy, ld_ready, ld_done, ld_err, rd_valid},
            {187'd0, m_loading | m_done, m_loading, m_done, m_err, exp_rd_valid});
        chk("rd_data", rd_data, exp_rd_data);
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic read_lane(input string name, input int addr, input int lane,
                             input logic [WIDTH-1:0] exp);
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
        cycle();
        rd_en   = 1'b0;
        chk(name, {160'd0, rd_data[lane*WIDTH +: WIDTH]}, {160'd0, exp});
    endtask

    task automatic load_words(input int n, input int base, input int last_at,
                              input bit gaps, input bit extras);
        for (int i = 0; i < n; i++) begin
            if (gaps)
                for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
                    ld_valid = 1'b0;
                    cycle();
                end
            ld_valid = 1'b1;
            ld_data  = WIDTH'(base + i);
            ld_last  = (i == last_at);
            if (extras && i == 7) begin
                rd_en   = 1'b1;
                rd_addr = 2'd1;
            end
            if (extras && i == 10) begin
                wr_en    = 1'b1;
                wr_addr  = 2'd0;
                wr_data  = '1;
                ld_start = 1'b1;
            end
            cycle();
            rd_en    = 1'b0;
            wr_en    = 1'b0;
            ld_start = 1'b0;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    logic [LANES*WIDTH-1:0] lit_vec;

    initial begin
        reset = 1'b0; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; sub_en = 1'b0; sub_lane = '0; sub_data = '0; ld_start = 1'b0;
        ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        cycle(); cycle();
        chk("reset_outputs", {187'd0, busy, ld_ready, ld_done, ld_err, rd_valid}, '0);
        chk("reset_rd_data", rd_data, '0);
        reset = 1'b1;
        cycle();

        // Full-entry write then read.
        wr_en = 1'b1; wr_addr = 2'd2;
        for (int k = 0; k < LANES; k++) wr_data[k*WIDTH +: WIDTH] = WIDTH'(32'h10 + k);
        cycle();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 2'd2;
        cycle();
        rd_en = 1'b0;
        for (int k = 0; k < LANES; k++) lit_vec[k*WIDTH +: WIDTH] = WIDTH'(32'h10 + k);
        chk("full_write_read", rd_data, lit_vec);
        chk("rd_valid_latency", {191'd0, rd_valid}, {191'd0, 1'b1});

        // Sub-word writes and merge.
        sub_en = 1'b1; sub_lane = 3'd3; sub_data = 32'hDEADBEEF; wr_addr = 2'd2;
        cycle();
        sub_en = 1'b0;
        read_lane("sub_lane3", 2, 3, 32'hDEADBEEF);
        read_lane("sub_lane2_kept", 2, 2, 32'h12);
        wr_en = 1'b1; sub_en = 1'b1; wr_addr = 2'd1; wr_data = {LANES{32'hAAAAAAAA}};
        sub_lane = 3'd0; sub_data = 32'h1;
        cycle();
        wr_en = 1'b0; sub_en = 1'b0;
        read_lane("merge_lane0", 1, 0, 32'h1);
        read_lane("merge_lane5", 1, 5, 32'hAAAAAAAA);
        sub_en = 1'b1; sub_lane = 3'd6; sub_data = 32'hBAD0BAD0; wr_addr = 2'd2;
        cycle();
        sub_en = 1'b0;
        read_lane("sub_lane_oob_lane0", 2, 0, 32'h10);

        // Write-first bypass.
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = {LANES{32'h55555555}};
        rd_en = 1'b1; rd_addr = 2'd0;
        cycle();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("bypass_read", rd_data, {LANES{32'h55555555}});

        // Full stream load with gaps, a blocked write and a stray ld_start.
        ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
        load_words(NW, 0, NW - 1, 1'b1, 1'b1);
        chk("load_done_pulse", {191'd0, ld_done}, {191'd0, 1'b1});
        cycle();
        chk("load_err_clear", {190'd0, ld_err, busy}, '0);
        read_lane("load_e3_l5", 3, 5, 32'd23);
        read_lane("load_e0_l0_wr_ignored", 0, 0, 32'd0);
        read_lane("load_e1_l2", 1, 2, 32'd8);

        // Early ld_last framing error.
        ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
        load_words(6, 200, 5, 1'b0, 1'b0);
        chk("early_last_done_err", {190'd0, ld_done, ld_err}, {190'd0, 2'b11});
        cycle();
        read_lane("early_e0_l5", 0, 5, 32'd205);
        read_lane("early_e1_l0_kept", 1, 0, 32'd6);
        read_lane("early_e2_l0_kept", 2, 0, 32'd12);
        ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
        chk("restart_clears_err", {191'd0, ld_err}, '0);

        // Reset mid-load.
        load_words(10, 300, -1, 1'b0, 1'b0);
        reset = 1'b0;
        model_reset();
        cycle(); cycle();
        chk("midload_reset", {190'd0, busy, ld_ready}, '0);
        reset = 1'b1;
        cycle();
        read_lane("midload_e0_l0", 0, 0, 32'd300);
        read_lane("midload_e1_l3", 1, 3, 32'd309);
        read_lane("midload_e1_l4_old", 1, 4, 32'd10);
        read_lane("midload_e3_l5_old", 3, 5, 32'd23);

        // Fresh complete load after reset.
        ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
        load_words(NW, 400, NW - 1, 1'b1, 1'b0);
        chk("reload_done", {191'd0, ld_done}, {191'd0, 1'b1});
        cycle();
        chk("reload_err", {191'd0, ld_err}, '0);
        for (int a = 0; a < DEPTH; a++) begin
            rd_en = 1'b1; rd_addr = AW'(a);
            cycle();
        end
        rd_en = 1'b0;
        read_lane("reload_e2_l1", 2, 1, 32'd413);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
